ex: RTL and testbench
=====================

EX -- requirements
Module: ex

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low.
REQ-003 stall  input  `StallBus  pipeline stall vector; bit 2 = ID held, bit 3 = EX held.
REQ-004 stallreq  output  1  EX requests pipeline hold (divide in progress).
REQ-005 id_to_ex_bus  input  `ID_TO_EX_WD (159)  {pc[158:127], inst[126:95], alu_op[94:83], sel_src1[82:80], sel_src2[79:76], ram_en[75], ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rs_data[63:32], rt_data[31:0]}.
REQ-006 ex_to_mem_bus  output  `EX_TO_MEM_WD (76)  {pc, ram_en, ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0]}.
REQ-007 ex_to_id_bus  output  `EX_TO_ID_WD (38)  forwarding {rf_we, rf_waddr, ex_result}.
REQ-008 data_sram_en / data_sram_wen[3:0] / data_sram_addr[31:0] / data_sram_wdata[31:0]  outputs  data memory request.

Function
REQ-009 Input register: stall[2]=Stop and stall[3]=NoStop loads all-zero bubble; stall[2]=NoStop loads id_to_ex_bus; otherwise holds.
REQ-010 src1 = rs_data (sel_src1[0]), pc (bit 1), zero-extended inst[10:6] (bit 2); src2 = rt_data (bit 0), sign-extended imm (bit 1), 32'd8 (bit 2), zero-extended imm (bit 3); one-hot, none selected gives 0.
REQ-011 alu_op one-hot order MSB..LSB: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui; add/sub wrap modulo 2^32, no overflow trap; shifts use src1[4:0] as amount on src2; lui = {src2[15:0],16'b0}.
REQ-012 ex_result combinational same cycle; mfhi (opcode 0, func 0x10) yields HI, mflo (func 0x12) yields LO, otherwise ALU result.
REQ-013 data_sram_en = ram_en, data_sram_wen = ram_wen, data_sram_addr = ex_result, data_sram_wdata = rt_data.
REQ-014 ex_to_id_bus and ex_to_mem_bus driven combinationally from the input register and ex_result; bubble yields all-zero.
REQ-015 div (opcode 0, func 0x1A, signed) and divu (func 0x1B) run a divider FSM: IDLE, BUSY, DONE.
REQ-016 IDLE->BUSY when div/divu present in register; BUSY iterates 32 restoring steps with 5-bit counter, ->DONE when counter = 31; DONE->IDLE unconditionally.
REQ-017 stallreq high in IDLE while div/divu present and in all BUSY cycles (33 cycles total), low in DONE.
REQ-018 HI<=remainder, LO<=quotient at end of DONE cycle; signed: quotient sign = xor of operand signs, remainder sign = dividend sign.
REQ-019 Divide-by-zero: LO=32'hFFFF_FFFF, HI=dividend, same 34-cycle timing.
REQ-020 Operands latched on IDLE->BUSY; changes to register contents during BUSY ignored.

Reset
REQ-021 rst low: input register zero, FSM IDLE, counter 0, HI=LO=0; all outputs 0 while asserted.
REQ-022 rst asserted mid-divide aborts it; HI/LO not updated by aborted operation.

Configuration
REQ-023 Macro EX_DIV_EN: defined compiles FSM, HI/LO, mfhi/mflo; undefined: div/divu/mfhi/mflo produce ex_result 0, stallreq tied 0, no HI/LO state.

Structure
REQ-024 `EX_TO_MEM_WD, `EX_TO_ID_WD, opcode/func constants in lib/defines.vh.
REQ-025 Divider as sub-module div_iter (start, signed, operands, busy, done, quotient, remainder).

Verification
REQ-026 addiu rs_data=5, imm=16'hFFFF -> ex_result=4, ex_to_id_bus rf_we=1 same cycle.
REQ-027 stall[2]=Stop, stall[3]=NoStop -> next cycle ex_to_mem_bus=0, data_sram_en=0.
REQ-028 div 32'hFFFF_FFF9 (-7) / 2 -> stallreq high 33 cycles, then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFD; mflo returns 32'hFFFF_FFFD.
REQ-029 divu 7/0 -> LO=32'hFFFF_FFFF, HI=7 after 34 cycles.
REQ-030 rst low at BUSY cycle 10 -> FSM IDLE, stallreq 0, HI/LO unchanged at 0.
REQ-031 sw-class bus ram_en=1, ram_wen=4'hF, rs_data=32'h100, imm=8 -> data_sram_addr=32'h108, wdata=rt_data.

Source files
------------

// File: rtl/ex_pkg.sv
// EX stage shared widths, opcodes, bus layout and divider states.
// The optional divider (HI/LO, div/divu/mfhi/mflo) is enabled by EX_DIV_EN.
package ex_pkg;

    localparam int STALL_WD     = 6;
    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 76;
    localparam int EX_TO_ID_WD  = 38;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;

    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_src1;
        logic [3:0]  sel_src2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
    } id_ex_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

    function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
        return n ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative 32-step restoring divider (signed/unsigned), EX stage helper.
// Only compiled when EX_DIV_EN is defined.
`ifdef EX_DIV_EN
module div_iter
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_t  state;
    logic [4:0]  cnt;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] d;
    logic [31:0] a_raw;
    logic        neg_q;
    logic        neg_r;
    logic        dz;
    logic [32:0] r_sh;
    logic [32:0] diff;

    assign r_sh = {r, q[31]};
    assign diff = r_sh - {1'b0, d};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DIV_IDLE;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            d     <= '0;
            a_raw <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
        end else begin
            unique case (state)
                DIV_IDLE: begin
                    if (start) begin
                        state <= DIV_BUSY;
                        cnt   <= '0;
                        r     <= '0;
                        q     <= neg_if(signed_op & dividend[31], dividend);
                        d     <= neg_if(signed_op & divisor[31], divisor);
                        a_raw <= dividend;
                        dz    <= (divisor == '0);
                        neg_q <= signed_op & (dividend[31] ^ divisor[31]);
                        neg_r <= signed_op & dividend[31];
                    end
                end
                DIV_BUSY: begin
                    // borrow out of the 33-bit trial subtract means restore
                    if (diff[32]) begin
                        r <= r_sh[31:0];
                        q <= {q[30:0], 1'b0};
                    end else begin
                        r <= diff[31:0];
                        q <= {q[30:0], 1'b1};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= DIV_DONE;
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

    assign busy      = (state == DIV_BUSY);
    assign done      = (state == DIV_DONE);
    assign quotient  = dz ? 32'hFFFF_FFFF : neg_if(neg_q, q);
    assign remainder = dz ? a_raw : neg_if(neg_r, r);

endmodule
`endif

// File: rtl/ex.sv
// EX pipeline stage: input register, ALU, memory request, forwarding.
// Define EX_DIV_EN to build the divider with HI/LO and mfhi/mflo.
module ex
    import ex_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    output logic                    stallreq,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    id_ex_t      r;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] alu_res;
    logic [31:0] ex_result;
    logic        is_special;
    logic        is_mfhi;
    logic        is_mflo;
    logic        is_div;
    logic        is_divu;
    logic        unused_bits;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r <= '0;
        else if (stall[2] == STOP && stall[3] == NO_STOP)
            r <= '0;
        else if (stall[2] == NO_STOP)
            r <= id_to_ex_bus;
    end

    assign src1 = ({32{r.sel_src1[0]}} & r.rs_data)
                | ({32{r.sel_src1[1]}} & r.pc)
                | ({32{r.sel_src1[2]}} & {27'b0, r.inst[10:6]});

    assign src2 = ({32{r.sel_src2[0]}} & r.rt_data)
                | ({32{r.sel_src2[1]}} & {{16{r.inst[15]}}, r.inst[15:0]})
                | ({32{r.sel_src2[2]}} & 32'd8)
                | ({32{r.sel_src2[3]}} & {16'b0, r.inst[15:0]});

    always_comb begin
        alu_res = '0;
        unique case (1'b1)
            r.alu_op[ALU_ADD]:  alu_res = src1 + src2;
            r.alu_op[ALU_SUB]:  alu_res = src1 - src2;
            r.alu_op[ALU_SLT]:  alu_res = {31'b0, $signed(src1) < $signed(src2)};
            r.alu_op[ALU_SLTU]: alu_res = {31'b0, src1 < src2};
            r.alu_op[ALU_AND]:  alu_res = src1 & src2;
            r.alu_op[ALU_NOR]:  alu_res = ~(src1 | src2);
            r.alu_op[ALU_OR]:   alu_res = src1 | src2;
            r.alu_op[ALU_XOR]:  alu_res = src1 ^ src2;
            r.alu_op[ALU_SLL]:  alu_res = src2 << src1[4:0];
            r.alu_op[ALU_SRL]:  alu_res = src2 >> src1[4:0];
            r.alu_op[ALU_SRA]:  alu_res = $signed(src2) >>> src1[4:0];
            r.alu_op[ALU_LUI]:  alu_res = {src2[15:0], 16'b0};
            default:            alu_res = '0;
        endcase
    end

    assign is_special = (r.inst[31:26] == OP_SPECIAL);
    assign is_mfhi    = is_special && (r.inst[5:0] == FN_MFHI);
    assign is_mflo    = is_special && (r.inst[5:0] == FN_MFLO);
    assign is_div     = is_special && (r.inst[5:0] == FN_DIV);
    assign is_divu    = is_special && (r.inst[5:0] == FN_DIVU);

`ifdef EX_DIV_EN
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        div_busy;
    logic        div_done;

    div_iter u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div | is_divu),
        .signed_op (is_div),
        .dividend  (r.rs_data),
        .divisor   (r.rt_data),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (div_done) begin
            hi <= rem;
            lo <= quo;
        end
    end

    // hold while waiting to start and while iterating; release in DONE
    assign stallreq = ((is_div | is_divu) & ~div_done) | div_busy;

    always_comb begin
        ex_result = alu_res;
        if (is_mfhi)
            ex_result = hi;
        else if (is_mflo)
            ex_result = lo;
    end
`else
    assign stallreq = 1'b0;

    always_comb begin
        ex_result = alu_res;
        if (is_mfhi | is_mflo | is_div | is_divu)
            ex_result = '0;
    end
`endif

    assign unused_bits = ^{stall[5:4], stall[1:0], r.inst[25:16]};

    assign ex_to_mem_bus = {r.pc, r.ram_en, r.ram_wen, r.sel_rf_res,
                            r.rf_we, r.rf_waddr, ex_result};
    assign ex_to_id_bus  = {r.rf_we, r.rf_waddr, ex_result};

    assign data_sram_en    = r.ram_en;
    assign data_sram_wen   = r.ram_wen;
    assign data_sram_addr  = ex_result;
    assign data_sram_wdata = r.rt_data;

endmodule

// File: tb/tb_ex.sv
// Self-checking bench for the EX stage: vector table through a scoreboard,
// plus hand sequences for stall, reset and (when built in) the divider.
module tb_ex;

    localparam logic [11:0] OP_ADD  = 12'h800;
    localparam logic [11:0] OP_SUB  = 12'h400;
    localparam logic [11:0] OP_SLT  = 12'h200;
    localparam logic [11:0] OP_SLTU = 12'h100;
    localparam logic [11:0] OP_AND  = 12'h080;
    localparam logic [11:0] OP_NOR  = 12'h040;
    localparam logic [11:0] OP_OR   = 12'h020;
    localparam logic [11:0] OP_XOR  = 12'h010;
    localparam logic [11:0] OP_SLL  = 12'h008;
    localparam logic [11:0] OP_SRL  = 12'h004;
    localparam logic [11:0] OP_SRA  = 12'h002;
    localparam logic [11:0] OP_LUI  = 12'h001;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] op;
        logic [2:0]  s1;
        logic [3:0]  s2;
        logic        ram_en;
        logic [3:0]  wen;
        logic        we;
        logic [4:0]  wa;
        logic        sel;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        string       name;
        logic [75:0] mem;
        logic [37:0] fwd;
        logic [68:0] sram;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic         stallreq;
    logic [158:0] id_bus;
    logic [75:0]  mem_bus;
    logic [37:0]  fwd_bus;
    logic         sram_en;
    logic [3:0]   sram_wen;
    logic [31:0]  sram_addr;
    logic [31:0]  sram_wdata;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vt[$];
    exp_t sb[$];
    vec_t v_sw;
    vec_t v_lw;

    always #5 clk = ~clk;

    ex dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .stallreq        (stallreq),
        .id_to_ex_bus    (id_bus),
        .ex_to_mem_bus   (mem_bus),
        .ex_to_id_bus    (fwd_bus),
        .data_sram_en    (sram_en),
        .data_sram_wen   (sram_wen),
        .data_sram_addr  (sram_addr),
        .data_sram_wdata (sram_wdata)
    );

    function automatic vec_t V(input string nm, input logic [31:0] pc,
                               input logic [31:0] inst, input logic [11:0] op,
                               input logic [2:0] s1, input logic [3:0] s2,
                               input logic ram_en, input logic [3:0] wen,
                               input logic we, input logic [4:0] wa,
                               input logic sel, input logic [31:0] rs,
                               input logic [31:0] rt, input logic [31:0] res);
        vec_t v;
        v.name = nm; v.pc = pc; v.inst = inst; v.op = op;
        v.s1 = s1; v.s2 = s2; v.ram_en = ram_en; v.wen = wen;
        v.we = we; v.wa = wa; v.sel = sel; v.rs = rs; v.rt = rt; v.res = res;
        return v;
    endfunction

    function automatic logic [158:0] mk(input vec_t v);
        return {v.pc, v.inst, v.op, v.s1, v.s2, v.ram_en, v.wen,
                v.we, v.wa, v.sel, v.rs, v.rt};
    endfunction

    function automatic exp_t mkexp(input vec_t v);
        exp_t e;
        e.name = v.name;
        e.mem  = {v.pc, v.ram_en, v.wen, v.sel, v.we, v.wa, v.res};
        e.fwd  = {v.we, v.wa, v.res};
        e.sram = {v.ram_en, v.wen, v.res, v.rt};
        return e;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cmp_out(input exp_t e);
        chk({e.name, ".mem"}, mem_bus, e.mem);
        chk({e.name, ".fwd"}, fwd_bus, e.fwd);
        chk({e.name, ".sram"}, {sram_en, sram_wen, sram_addr, sram_wdata}, e.sram);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".mem"}, mem_bus, 0);
        chk({nm, ".fwd"}, fwd_bus, 0);
        chk({nm, ".sram"}, {sram_en, sram_wen, sram_addr, sram_wdata}, 0);
        chk({nm, ".stallreq"}, stallreq, 0);
    endtask

`ifdef EX_DIV_EN
    task automatic read_hilo(input string nm, input logic [31:0] hi,
                             input logic [31:0] lo);
        id_bus = mk(V("mflo", 0, 32'h0000_1812, 12'h0, 3'b0, 4'b0, 1'b0,
                      4'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0, 32'h0));
        @(negedge clk);
        chk({nm, ".mflo"}, mem_bus[31:0], lo);
        id_bus = mk(V("mfhi", 0, 32'h0000_1810, 12'h0, 3'b0, 4'b0, 1'b0,
                      4'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0, 32'h0));
        @(negedge clk);
        chk({nm, ".mfhi"}, mem_bus[31:0], hi);
    endtask

    task automatic run_div(input string nm, input logic [31:0] inst,
                           input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] hi, input logic [31:0] lo);
        int n;
        stall  = 6'b0;
        id_bus = mk(V(nm, 0, inst, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0,
                      5'd0, 1'b0, rs, rt, 32'h0));
        @(negedge clk);
        n = 0;
        while (stallreq && n < 100) begin
            stall = 6'b001111;
            n++;
            @(negedge clk);
        end
        chk({nm, ".stall_cycles"}, n, 33);
        stall = 6'b0;
        read_hilo(nm, hi, lo);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt.push_back(V("addiu", 32'hBFC0_0000, 32'h2422_FFFF, OP_ADD, 3'b001, 4'b0010,
                       1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd5, 32'h0, 32'd4));
        vt.push_back(V("subu", 32'hBFC0_0004, 32'h0064_2023, OP_SUB, 3'b001, 4'b0001,
                       1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'd3, 32'd5, 32'hFFFF_FFFE));
        vt.push_back(V("addu_wrap", 32'hBFC0_0008, 32'h0064_2021, OP_ADD, 3'b001, 4'b0001,
                       1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd1));
        vt.push_back(V("slt", 32'hBFC0_000C, 32'h0064_202A, OP_SLT, 3'b001, 4'b0001,
                       1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1));
        vt.push_back(V("sltu", 32'hBFC0_000C, 32'h0064_202B, OP_SLTU, 3'b001, 4'b0001,
                       1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0));
        vt.push_back(V("and", 32'hBFC0_0010, 32'h0064_2024, OP_AND, 3'b001, 4'b0001,
                       1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00,
                       32'h00F0_1200));
        vt.push_back(V("nor", 32'hBFC0_0014, 32'h0064_2027, OP_NOR, 3'b001, 4'b0001,
                       1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'hF0F0_0000, 32'h0F00_000F,
                       32'h000F_FFF0));
        vt.push_back(V("ori_zext", 32'hBFC0_0018, 32'h3482_8000, OP_OR, 3'b001, 4'b1000,
                       1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd1, 32'h0, 32'h0000_8001));
        vt.push_back(V("xor", 32'hBFC0_001C, 32'h0064_2026, OP_XOR, 3'b001, 4'b0001,
                       1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'hFFFF_0000, 32'hFF00_FF00,
                       32'h00FF_FF00));
        vt.push_back(V("sll_sa", 32'hBFC0_0020, 32'h0003_2100, OP_SLL, 3'b100, 4'b0001,
                       1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'hFFFF_FFFF, 32'h0000_000F,
                       32'h0000_00F0));
        vt.push_back(V("srl_sa", 32'hBFC0_0024, 32'h0003_2102, OP_SRL, 3'b100, 4'b0001,
                       1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'h0, 32'h8000_0000, 32'h0800_0000));
        vt.push_back(V("sra_sa", 32'hBFC0_0028, 32'h0003_2103, OP_SRA, 3'b100, 4'b0001,
                       1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'h0, 32'h8000_0000, 32'hF800_0000));
        vt.push_back(V("srav_31", 32'hBFC0_002C, 32'h0064_2007, OP_SRA, 3'b001, 4'b0001,
                       1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'h0000_003F, 32'h8000_0001,
                       32'hFFFF_FFFF));
        vt.push_back(V("sllv", 32'hBFC0_0030, 32'h0064_2004, OP_SLL, 3'b001, 4'b0001,
                       1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'h0000_0024, 32'd1, 32'h10));
        vt.push_back(V("lui", 32'hBFC0_0034, 32'h3C04_1234, OP_LUI, 3'b000, 4'b1000,
                       1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'h0, 32'h0, 32'h1234_0000));
        vt.push_back(V("jal_link", 32'hBFC0_0010, 32'h0C00_0000, OP_ADD, 3'b010, 4'b0100,
                       1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'h0, 32'h0, 32'hBFC0_0018));
        v_sw = V("sw", 32'hBFC0_0040, 32'hAC43_0008, OP_ADD, 3'b001, 4'b0010,
                 1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h108);
        vt.push_back(v_sw);
        v_lw = V("lw", 32'hBFC0_0044, 32'h8C44_FFFC, OP_ADD, 3'b001, 4'b0010,
                 1'b1, 4'h0, 1'b1, 5'd4, 1'b1, 32'h100, 32'h0, 32'hFC);
        vt.push_back(v_lw);
        vt.push_back(V("no_op", 32'hBFC0_0048, 32'h0000_0000, 12'h0, 3'b000, 4'b0000,
                       1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0));

        rst    = 1'b1;
        stall  = 6'b0;
        id_bus = '0;
        #2;
        rst    = 1'b0;
        id_bus = mk(v_sw);
        @(negedge clk);
        chk_zero("reset");
        @(negedge clk);
        chk_zero("reset_hold");
        rst = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            id_bus = mk(vt[i]);
            sb.push_back(mkexp(vt[i]));
            @(negedge clk);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard: empty queue at vector %0d", i);
            end else begin
                cmp_out(sb.pop_front());
            end
        end

        id_bus = mk(v_sw);
        @(negedge clk);
        cmp_out(mkexp(v_sw));
        stall  = 6'b001100;
        id_bus = mk(v_lw);
        @(negedge clk);
        cmp_out(mkexp(v_sw));
        stall = 6'b000100;
        @(negedge clk);
        chk_zero("bubble");
        stall = 6'b0;
        @(negedge clk);
        cmp_out(mkexp(v_lw));

        rst = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;

`ifdef EX_DIV_EN
        run_div("div_neg7_2", 32'h0000_001A, 32'hFFFF_FFF9, 32'd2,
                32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div("div_7_neg2", 32'h0000_001A, 32'd7, 32'hFFFF_FFFE,
                32'd1, 32'hFFFF_FFFD);
        run_div("divu_100_7", 32'h0000_001B, 32'd100, 32'd7, 32'd2, 32'd14);
        run_div("divu_big", 32'h0000_001B, 32'hFFFF_FFF9, 32'd2,
                32'd1, 32'h7FFF_FFFC);
        run_div("divu_by0", 32'h0000_001B, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        run_div("div_by0", 32'h0000_001A, 32'hFFFF_FFF0, 32'd0,
                32'hFFFF_FFF0, 32'hFFFF_FFFF);

        begin
            int seen;
            stall  = 6'b0;
            id_bus = mk(V("div_abort", 0, 32'h0000_001B, 12'h0, 3'b0, 4'b0, 1'b0,
                          4'h0, 1'b0, 5'd0, 1'b0, 32'd100, 32'd7, 32'h0));
            @(negedge clk);
            stall = 6'b001111;
            repeat (10) @(negedge clk);
            chk("abort.busy_before", stallreq, 1);
            rst = 1'b0;
            #1;
            chk_zero("abort.in_reset");
            @(negedge clk);
            rst    = 1'b1;
            stall  = 6'b0;
            id_bus = '0;
            seen   = 0;
            repeat (40) begin
                @(negedge clk);
                if (stallreq) seen++;
            end
            chk("abort.stallreq_after", seen, 0);
            read_hilo("abort", 32'h0, 32'h0);
        end
`else
        begin
            logic [31:0] ins[4];
            ins[0] = 32'h0064_001A;
            ins[1] = 32'h0064_001B;
            ins[2] = 32'h0000_2010;
            ins[3] = 32'h0000_2012;
            for (int i = 0; i < 4; i++) begin
                id_bus = mk(V("nodiv", 32'hBFC0_0100, ins[i], OP_ADD, 3'b001, 4'b0001,
                              1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'd5, 32'd3, 32'h0));
                @(negedge clk);
                chk($sformatf("nodiv%0d.result", i), mem_bus[31:0], 0);
                chk($sformatf("nodiv%0d.stallreq", i), stallreq, 0);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
